// File: rtl/otp_access_ctrl.sv
// rtl/otp_access_ctrl.sv - eFuse/OTP macro sequencer with fixed-priority boot/host arbitration
// Boot reads beat host requests; each access runs the full CSB/LOAD/STROBE/PGENB/VDDQ pulse train.
module otp_access_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int T_SETUP = 2,
  parameter int T_RD    = 4,
  parameter int T_PG    = 20,
  parameter int T_HOLD  = 2,
  parameter int T_VDDQ  = 4
) (
  input  logic              xtal_clk,
  input  logic              por_rst_n,
  input  logic              boot_req,
  input  logic [ADDR_W-1:0] boot_addr,
  output logic              boot_ack,
  output logic [DATA_W-1:0] boot_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              prog_unlock,
  output logic              host_ack,
  output logic              host_err,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              o_otp_csb,
  output logic              o_otp_load,
  output logic              o_otp_strobe,
  output logic              o_otp_pgenb,
  output logic              o_otp_vddqsw,
  output logic [ADDR_W-1:0] o_otp_addr,
  input  logic [DATA_W-1:0] i_otp_q
);

  localparam int T_M1  = (T_SETUP > T_RD) ? T_SETUP : T_RD;
  localparam int T_M2  = (T_PG > T_HOLD) ? T_PG : T_HOLD;
  localparam int T_M3  = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int T_MAX = (T_M3 > T_VDDQ) ? T_M3 : T_VDDQ;
  localparam int CNT_W = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_SETUP, S_STROBE, S_HOLD, S_PWRDN, S_ACK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sel_boot;
  logic             op_prog;

  // A state lasting t cycles is entered with t-1 and left when the counter reaches zero.
  function automatic logic [CNT_W-1:0] ld_cnt(input int t);
    return CNT_W'(t - 1);
  endfunction

  always_ff @(posedge xtal_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sel_boot     <= 1'b0;
      op_prog      <= 1'b0;
      busy         <= 1'b0;
      boot_ack     <= 1'b0;
      host_ack     <= 1'b0;
      host_err     <= 1'b0;
      boot_rdata   <= '0;
      host_rdata   <= '0;
      o_otp_csb    <= 1'b1;
      o_otp_load   <= 1'b0;
      o_otp_strobe <= 1'b0;
      o_otp_pgenb  <= 1'b1;
      o_otp_vddqsw <= 1'b0;
      o_otp_addr   <= '0;
    end else begin
      boot_ack <= 1'b0;
      host_ack <= 1'b0;
      host_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (boot_req) begin
            busy       <= 1'b1;
            sel_boot   <= 1'b1;
            op_prog    <= 1'b0;
            o_otp_addr <= boot_addr;
            o_otp_csb  <= 1'b0;
            o_otp_load <= 1'b1;
            cnt        <= ld_cnt(T_SETUP);
            state      <= S_SETUP;
          end else if (host_req) begin
            busy     <= 1'b1;
            sel_boot <= 1'b0;
            op_prog  <= host_we;
            if (host_we && !prog_unlock) begin
              // Refused program never touches the macro pins.
              host_ack <= 1'b1;
              host_err <= 1'b1;
              cnt      <= '0;
              state    <= S_ACK;
            end else if (host_we) begin
              o_otp_addr   <= host_addr;
              o_otp_vddqsw <= 1'b1;
              cnt          <= ld_cnt(T_VDDQ);
              state        <= S_PWRUP;
            end else begin
              o_otp_addr <= host_addr;
              o_otp_csb  <= 1'b0;
              o_otp_load <= 1'b1;
              cnt        <= ld_cnt(T_SETUP);
              state      <= S_SETUP;
            end
          end
        end
        S_PWRUP: begin
          if (cnt == '0) begin
            o_otp_csb   <= 1'b0;
            o_otp_load  <= 1'b0;
            o_otp_pgenb <= 1'b0;
            cnt         <= ld_cnt(T_SETUP);
            state       <= S_SETUP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            o_otp_strobe <= 1'b1;
            cnt          <= op_prog ? ld_cnt(T_PG) : ld_cnt(T_RD);
            state        <= S_STROBE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_STROBE: begin
          if (cnt == '0) begin
            // Q is sampled on the last strobe-high cycle, before the strobe falls.
            if (!op_prog) begin
              if (sel_boot) boot_rdata <= i_otp_q;
              else          host_rdata <= i_otp_q;
            end
            o_otp_strobe <= 1'b0;
            cnt          <= ld_cnt(T_HOLD);
            state        <= S_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            o_otp_csb   <= 1'b1;
            o_otp_pgenb <= 1'b1;
            if (op_prog) begin
              cnt   <= ld_cnt(T_VDDQ);
              state <= S_PWRDN;
            end else begin
              o_otp_load <= 1'b0;
              o_otp_addr <= '0;
              boot_ack   <= sel_boot;
              host_ack   <= !sel_boot;
              cnt        <= '0;
              state      <= S_ACK;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_PWRDN: begin
          if (cnt == '0) begin
            o_otp_vddqsw <= 1'b0;
            o_otp_addr   <= '0;
            boot_ack     <= sel_boot;
            host_ack     <= !sel_boot;
            cnt          <= '0;
            state        <= S_ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_ACK: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otp_access_ctrl.sv
// tb/tb_otp_access_ctrl.sv - self-checking bench for otp_access_ctrl
// Behavioural OTP macro plus a byte-array reference model of expected contents.
`timescale 1ns/1ps
module tb_otp_access_ctrl;

  localparam int ADDR_W = 10, DATA_W = 8;
  localparam int T_SETUP = 2, T_RD = 4, T_PG = 20, T_HOLD = 2, T_VDDQ = 4;
  localparam int LAT_RD = T_SETUP + T_RD + T_HOLD;
  localparam int LAT_PG = 2 * T_VDDQ + T_SETUP + T_PG + T_HOLD;

  logic              xtal_clk = 1'b0;
  logic              por_rst_n = 1'b0;
  logic              boot_req = 1'b0, host_req = 1'b0, host_we = 1'b0, prog_unlock = 1'b0;
  logic [ADDR_W-1:0] boot_addr = '0, host_addr = '0;
  logic              boot_ack, host_ack, host_err, busy;
  logic [DATA_W-1:0] boot_rdata, host_rdata, i_otp_q;
  logic              o_otp_csb, o_otp_load, o_otp_strobe, o_otp_pgenb, o_otp_vddqsw;
  logic [ADDR_W-1:0] o_otp_addr;

  otp_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_SETUP(T_SETUP), .T_RD(T_RD),
    .T_PG(T_PG), .T_HOLD(T_HOLD), .T_VDDQ(T_VDDQ)
  ) dut (
    .xtal_clk(xtal_clk), .por_rst_n(por_rst_n),
    .boot_req(boot_req), .boot_addr(boot_addr), .boot_ack(boot_ack), .boot_rdata(boot_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .prog_unlock(prog_unlock),
    .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata), .busy(busy),
    .o_otp_csb(o_otp_csb), .o_otp_load(o_otp_load), .o_otp_strobe(o_otp_strobe),
    .o_otp_pgenb(o_otp_pgenb), .o_otp_vddqsw(o_otp_vddqsw), .o_otp_addr(o_otp_addr),
    .i_otp_q(i_otp_q)
  );

  always #5 xtal_clk = ~xtal_clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge xtal_clk) cyc <= cyc + 1;

  // Macro model: byte-wide read, a program sets bit addr[2:0] of byte addr>>3 after a full T_PG strobe.
  logic [7:0] otp_mem [0:1023];
  logic [7:0] ref_mem [0:1023];
  int pg_len = 0;
  assign i_otp_q = (!o_otp_csb && o_otp_load && o_otp_pgenb && o_otp_strobe) ? otp_mem[o_otp_addr] : 8'hEE;
  always @(posedge xtal_clk) begin
    if (!o_otp_csb && !o_otp_pgenb && o_otp_vddqsw && o_otp_strobe) begin
      pg_len <= pg_len + 1;
      if (pg_len + 1 == T_PG) otp_mem[o_otp_addr >> 3][o_otp_addr[2:0]] <= 1'b1;
    end else begin
      pg_len <= 0;
    end
  end

  // Pin monitor: cumulative counters; tasks compare deltas.
  int n_csb = 0, n_str = 0, n_vq = 0, n_pg = 0, n_ba = 0, n_ha = 0, n_bad = 0, strobe_rise_cyc = 0;
  logic [ADDR_W-1:0] mon_addr = '0;
  logic csb_prev = 1'b1, load_prev = 1'b0, pgenb_prev = 1'b1, strobe_prev = 1'b0;
  logic pin_bad;
  assign pin_bad =
      (!o_otp_csb && o_otp_addr != mon_addr) ||
      ((o_otp_strobe || o_otp_load || !o_otp_pgenb) && o_otp_csb) ||
      (!o_otp_csb && !csb_prev && (o_otp_load != load_prev || o_otp_pgenb != pgenb_prev)) ||
      (!busy && (!o_otp_csb || o_otp_load || o_otp_strobe || !o_otp_pgenb || o_otp_vddqsw || o_otp_addr != '0));
  always @(negedge xtal_clk) begin
    csb_prev <= o_otp_csb; load_prev <= o_otp_load; pgenb_prev <= o_otp_pgenb; strobe_prev <= o_otp_strobe;
    if (o_otp_strobe && !strobe_prev) strobe_rise_cyc <= cyc;
    if (!o_otp_csb)   n_csb <= n_csb + 1;
    if (o_otp_strobe) n_str <= n_str + 1;
    if (o_otp_vddqsw) n_vq  <= n_vq + 1;
    if (!o_otp_pgenb) n_pg  <= n_pg + 1;
    if (boot_ack)     n_ba  <= n_ba + 1;
    if (host_ack)     n_ha  <= n_ha + 1;
    if (pin_bad)      n_bad <= n_bad + 1;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic              boot;
    logic              we;
    logic              unlock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp_data;
    logic              exp_err;
    int                exp_lat;
  } vec_t;

  task automatic wait_ack(input logic boot, input int bound, output logic got, output int t);
    got = 1'b0;
    t = 0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge xtal_clk);
      if ((boot && boot_ack) || (!boot && host_ack)) begin
        got = 1'b1;
        t = cyc;
      end
    end
  endtask

  task automatic run_access(input vec_t v, input string nm);
    int c0, t, b_csb, b_str, b_vq, b_pg, b_bad, b_ba, b_ha;
    logic got, prog_ok, refused;
    prog_ok = !v.boot && v.we && v.unlock;
    refused = !v.boot && v.we && !v.unlock;
    @(posedge xtal_clk); #1;
    b_csb = n_csb; b_str = n_str; b_vq = n_vq; b_pg = n_pg; b_bad = n_bad; b_ba = n_ba; b_ha = n_ha;
    mon_addr = v.addr;
    c0 = cyc + 1;
    if (v.boot) begin
      boot_req = 1'b1; boot_addr = v.addr;
    end else begin
      host_req = 1'b1; host_we = v.we; host_addr = v.addr; prog_unlock = v.unlock;
    end
    wait_ack(v.boot, 100, got, t);
    chk({nm, " ack_seen"}, got, 1);
    if (got) begin
      chk({nm, " latency"}, t - c0, v.exp_lat);
      if (v.boot) chk({nm, " boot_rdata"}, boot_rdata, v.exp_data);
      else begin
        chk({nm, " host_err"}, host_err, v.exp_err);
        if (!v.we) chk({nm, " host_rdata"}, host_rdata, v.exp_data);
      end
    end
    @(posedge xtal_clk); #1;
    boot_req = 1'b0; host_req = 1'b0;
    @(negedge xtal_clk);
    chk({nm, " ack_one_cycle"}, {boot_ack, host_ack}, 0);
    chk({nm, " busy_after"}, busy, 0);
    #1;
    chk({nm, " csb_low_cycles"}, n_csb - b_csb, refused ? 0 : (prog_ok ? T_SETUP + T_PG + T_HOLD : LAT_RD));
    chk({nm, " strobe_cycles"}, n_str - b_str, refused ? 0 : (prog_ok ? T_PG : T_RD));
    chk({nm, " vddqsw_cycles"}, n_vq - b_vq, prog_ok ? LAT_PG : 0);
    chk({nm, " pgenb_low_cycles"}, n_pg - b_pg, prog_ok ? T_SETUP + T_PG + T_HOLD : 0);
    chk({nm, " pin_rules"}, n_bad - b_bad, 0);
    chk({nm, " boot_ack_count"}, n_ba - b_ba, v.boot ? 1 : 0);
    chk({nm, " host_ack_count"}, n_ha - b_ha, v.boot ? 0 : 1);
  endtask

  vec_t vecs [8];
  vec_t rv;
  logic got;
  int t_b, t_h, b_ha;
  logic [7:0] saved_boot;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      otp_mem[i] = 8'h00; ref_mem[i] = 8'h00;
    end
    otp_mem[10'h005] = 8'hA5; ref_mem[10'h005] = 8'hA5;
    otp_mem[10'h010] = 8'h5A; ref_mem[10'h010] = 8'h5A;
    otp_mem[10'h3FF] = 8'hC3; ref_mem[10'h3FF] = 8'hC3;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 10'h005, 8'hA5, 1'b0, LAT_RD};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 10'h010, 8'h5A, 1'b0, LAT_RD};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 10'h123, 8'h00, 1'b0, LAT_PG};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 10'h024, 8'h08, 1'b0, LAT_RD};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 10'h2A0, 8'h00, 1'b1, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 10'h054, 8'h00, 1'b0, LAT_RD};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 10'h3FF, 8'hC3, 1'b0, LAT_RD};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, LAT_RD};

    repeat (3) @(negedge xtal_clk);
    chk("reset pins", {o_otp_csb, o_otp_load, o_otp_strobe, o_otp_pgenb, o_otp_vddqsw}, 5'b10010);
    chk("reset addr", o_otp_addr, 0);
    chk("reset acks", {boot_ack, host_ack, host_err, busy}, 0);
    chk("reset rdata", {boot_rdata, host_rdata}, 0);
    @(posedge xtal_clk); #1;
    por_rst_n = 1'b1;
    repeat (2) @(negedge xtal_clk);
    chk("idle busy", busy, 0);

    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i], $sformatf("vec%0d", i));
      if (!vecs[i].boot && vecs[i].we && vecs[i].unlock)
        ref_mem[vecs[i].addr >> 3][vecs[i].addr[2:0]] = 1'b1;
    end

    for (int i = 0; i < 40; i++) begin
      rv.boot   = ($urandom_range(0, 1) == 1);
      rv.we     = !rv.boot && ($urandom_range(0, 2) == 0);
      rv.unlock = ($urandom_range(0, 3) != 0);
      rv.addr   = rv.we ? 10'($urandom_range(0, 511)) : 10'($urandom_range(0, 63));
      rv.exp_data = rv.we ? 8'h00 : ref_mem[rv.addr];
      rv.exp_err  = rv.we && !rv.unlock;
      rv.exp_lat  = !rv.we ? LAT_RD : (rv.unlock ? LAT_PG : 0);
      run_access(rv, $sformatf("rnd%0d", i));
      if (rv.we && rv.unlock) ref_mem[rv.addr >> 3][rv.addr[2:0]] = 1'b1;
    end

    // Simultaneous requests: boot first, host in the IDLE cycle after boot ACK.
    @(posedge xtal_clk); #1;
    mon_addr = 10'h005;
    boot_req = 1'b1; boot_addr = 10'h005;
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h010;
    wait_ack(1'b1, 100, got, t_b);
    chk("arb boot first", got, 1);
    chk("arb no host ack", host_ack, 0);
    chk("arb boot rdata", boot_rdata, ref_mem[10'h005]);
    saved_boot = boot_rdata;
    @(posedge xtal_clk); #1;
    boot_req = 1'b0;
    mon_addr = 10'h010;
    wait_ack(1'b0, 100, got, t_h);
    chk("arb host ack", got, 1);
    chk("arb host latency", t_h - t_b, 2 + LAT_RD);
    chk("arb host rdata", host_rdata, ref_mem[10'h010]);
    chk("arb boot rdata kept", boot_rdata, saved_boot);
    chk("arb host strobe after boot ack", strobe_rise_cyc > t_b, 1);
    @(posedge xtal_clk); #1;
    host_req = 1'b0;

    // Request dropped and address changed mid-strobe.
    @(posedge xtal_clk); #1;
    b_ha = n_ha;
    mon_addr = 10'h010;
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h010;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge xtal_clk);
      got = o_otp_strobe;
    end
    chk("drop strobe seen", got, 1);
    #1;
    host_req = 1'b0; host_addr = 10'h3FF;
    wait_ack(1'b0, 50, got, t_h);
    chk("drop ack", got, 1);
    chk("drop rdata", host_rdata, ref_mem[10'h010]);
    repeat (10) @(negedge xtal_clk);
    #1;
    chk("drop single ack", n_ha - b_ha, 1);

    // Reset in the middle of a program strobe.
    @(posedge xtal_clk); #1;
    mon_addr = 10'h3F7;
    host_req = 1'b1; host_we = 1'b1; prog_unlock = 1'b1; host_addr = 10'h3F7;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge xtal_clk);
      got = o_otp_strobe;
    end
    chk("rst strobe seen", got, 1);
    repeat (5) @(negedge xtal_clk);
    #2;
    b_ha = n_ha;
    por_rst_n = 1'b0;
    #1;
    chk("rst pins idle", {o_otp_csb, o_otp_load, o_otp_strobe, o_otp_pgenb, o_otp_vddqsw}, 5'b10010);
    chk("rst busy", busy, 0);
    host_req = 1'b0;
    @(posedge xtal_clk); #1;
    por_rst_n = 1'b1;
    repeat (10) @(negedge xtal_clk);
    #1;
    chk("rst no ack", n_ha - b_ha, 0);
    chk("rst rdata cleared", {boot_rdata, host_rdata}, 0);
    chk("rst macro unchanged", otp_mem[10'h07E], ref_mem[10'h07E]);
    rv = '{1'b0, 1'b0, 1'b0, 10'h07E, ref_mem[10'h07E], 1'b0, LAT_RD};
    run_access(rv, "post_rst_read");
    rv = '{1'b1, 1'b0, 1'b0, 10'h005, ref_mem[10'h005], 1'b0, LAT_RD};
    run_access(rv, "post_rst_boot");

    chk("pin rules total", n_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
